weight_stream_tx: RTL and testbench

WEIGHT_STREAM_TX -- requirements
Module: weight_stream_tx

---
 rtl/weight_stream_tx.sv | 116 +++++++++++
 tb/tb_weight_stream_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_tx.sv
// Streams row-vector weight beats onto the north edge of a systolic array,
// then walks a one-hot switch pulse down the west edge so that each PE row flips its weight bank.
module weight_stream_tx #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_IN        = 8,
    localparam int IW                  = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        wr_valid,
    output logic                                        wr_ready,
    input  logic [IW-1:0]                               wr_row,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0] wr_data,
    input  logic                                        wr_last,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]             col_enable,
    output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0] w_weight_out,
    output logic [SYSTOLIC_ARRAY_WIDTH*IW-1:0]          w_index_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]             w_accept_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]             sw_switch_out,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err
);

    localparam int N  = SYSTOLIC_ARRAY_WIDTH;
    localparam int W  = DATA_WIDTH_IN;
    localparam int CW = $clog2(N + 1);
    localparam logic [IW:0]   N_ROWS   = (IW + 1)'(N);
    localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SWITCH} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [N*W-1:0]    weight_q, weight_d;
    logic [N*IW-1:0]   index_q, index_d;
    logic [N-1:0]      accept_q, accept_d;
    logic              beat;
    logic              row_ok;

    assign wr_ready = !rst && (state_q == IDLE || state_q == LOAD);
    assign beat     = wr_valid && wr_ready;
    assign row_ok   = {1'b0, wr_row} < N_ROWS;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (beat) state_d = wr_last ? DRAIN : LOAD;
            end
            DRAIN: begin
                state_d = SWITCH;
                cnt_d   = '0;
            end
            SWITCH: begin
                if (cnt_q == LAST_ROW) state_d = IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // An out-of-range row is consumed but turns into a bubble on every column.
    always_comb begin
        weight_d = '0;
        index_d  = '0;
        accept_d = '0;
        err_d    = err_q | (beat && !row_ok);
        if (beat && row_ok) begin
            for (int c = 0; c < N; c++) begin
                if (col_enable[c]) begin
                    accept_d[c]            = 1'b1;
                    weight_d[c*W +: W]     = wr_data[c*W +: W];
                    index_d[c*IW +: IW]    = wr_row;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            weight_q <= '0;
            index_q  <= '0;
            accept_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            weight_q <= weight_d;
            index_q  <= index_d;
            accept_q <= accept_d;
        end
    end

    // NOTE: outputs are masked by rst so they drop in the same cycle rst rises, not one edge later.
    assign w_weight_out = rst ? '0 : weight_q;
    assign w_index_out  = rst ? '0 : index_q;
    assign w_accept_out = rst ? '0 : accept_q;
    assign busy         = !rst && (state_q != IDLE);
    assign done         = !rst && (state_q == SWITCH) && (cnt_q == LAST_ROW);
    assign err          = !rst && err_q;

    // One-hot walk: row r switches in the r-th SWITCH cycle, after its weights have already passed.
    always_comb begin
        sw_switch_out = '0;
        if (!rst && state_q == SWITCH) sw_switch_out = N'(1) << cnt_q;
    end

endmodule

// File: tb/tb_weight_stream_tx.sv
// Directed bench for weight_stream_tx: an N=4 instance for streaming/switch timing,
// and an N=6 instance for the out-of-range row and sticky error behaviour.
module tb_weight_stream_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // N=4, W=8 instance
    logic        a_valid = 1'b0, a_ready, a_last = 1'b0;
    logic [1:0]  a_row = '0;
    logic [31:0] a_data = '0, a_weight;
    logic [3:0]  a_en = '0, a_accept, a_sw;
    logic [7:0]  a_index;
    logic        a_busy, a_done, a_err;
    logic [7:0]  a_status;
    logic [43:0] a_w;

    // N=6, W=8 instance
    logic        b_valid = 1'b0, b_ready, b_last = 1'b0;
    logic [2:0]  b_row = '0;
    logic [47:0] b_data = '0, b_weight;
    logic [5:0]  b_en = '0, b_accept, b_sw;
    logic [17:0] b_index;
    logic        b_busy, b_done, b_err;
    logic [71:0] b_w;

    assign a_status = {a_ready, a_busy, a_done, a_err, a_sw};
    assign a_w      = {a_accept, a_index, a_weight};
    assign b_w      = {b_accept, b_index, b_weight};

    weight_stream_tx #(.SYSTOLIC_ARRAY_WIDTH(4), .DATA_WIDTH_IN(8)) dut_a (
        .clk(clk), .rst(rst), .wr_valid(a_valid), .wr_ready(a_ready), .wr_row(a_row),
        .wr_data(a_data), .wr_last(a_last), .col_enable(a_en), .w_weight_out(a_weight),
        .w_index_out(a_index), .w_accept_out(a_accept), .sw_switch_out(a_sw),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    weight_stream_tx #(.SYSTOLIC_ARRAY_WIDTH(6), .DATA_WIDTH_IN(8)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(b_valid), .wr_ready(b_ready), .wr_row(b_row),
        .wr_data(b_data), .wr_last(b_last), .col_enable(b_en), .w_weight_out(b_weight),
        .w_index_out(b_index), .w_accept_out(b_accept), .sw_switch_out(b_sw),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (a_status !== 8'h00) begin
            failures++; $display("FAIL reset_status got=%h exp=%h", a_status, 8'h00);
        end
        checks++;
        if (a_w !== 44'h0) begin
            failures++; $display("FAIL reset_w got=%h exp=%h", a_w, 44'h0);
        end
        checks++;
        if ({b_ready, b_busy, b_err, b_sw} !== 9'h0) begin
            failures++; $display("FAIL reset_b got=%h exp=%h", {b_ready, b_busy, b_err, b_sw}, 9'h0);
        end
        a_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (a_status !== 8'h80) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", a_status, 8'h80);
        end
    endtask

    task automatic test_load_sequence();
        logic [7:0] exp_s;
        for (int r = 0; r < 4; r++) begin
            a_row = 2'(r); a_last = (r == 3); a_en = 4'hF; a_valid = 1'b1;
            for (int c = 0; c < 4; c++) a_data[c*8 +: 8] = 8'(16 * r + c);
            tick();
            checks++;
            if (a_w !== {4'hF, {4{2'(r)}}, a_data}) begin
                failures++; $display("FAIL load_w row=%0d got=%h exp=%h", r, a_w, {4'hF, {4{2'(r)}}, a_data});
            end
            exp_s = (r < 3) ? 8'hC0 : 8'h40;
            checks++;
            if (a_status !== exp_s) begin
                failures++; $display("FAIL load_status row=%0d got=%h exp=%h", r, a_status, exp_s);
            end
        end
        a_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick();
            exp_s = {1'b0, 1'b1, (r == 3), 1'b0, 4'(1 << r)};
            checks++;
            if (a_status !== exp_s || a_w !== 44'h0) begin
                failures++; $display("FAIL load_switch step=%0d got=%h/%h exp=%h/0", r, a_status, a_w, exp_s);
            end
        end
        tick();
        checks++;
        if (a_status !== 8'h80) begin
            failures++; $display("FAIL load_idle got=%h exp=%h", a_status, 8'h80);
        end
    endtask

    task automatic test_single_beat();
        logic [7:0] exp_s;
        a_row = 2'd2; a_last = 1'b1; a_en = 4'hF; a_data = 32'hA1B2C3D4; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        checks++;
        if (a_w !== {4'hF, 8'b1010_1010, 32'hA1B2C3D4} || a_status !== 8'h40) begin
            failures++; $display("FAIL single_beat got=%h/%h exp=%h/40", a_w, a_status,
                                 {4'hF, 8'b1010_1010, 32'hA1B2C3D4});
        end
        for (int r = 0; r < 4; r++) begin
            tick();
            exp_s = {1'b0, 1'b1, (r == 3), 1'b0, 4'(1 << r)};
            checks++;
            if (a_status !== exp_s) begin
                failures++; $display("FAIL single_switch step=%0d got=%h exp=%h", r, a_status, exp_s);
            end
        end
        tick();
        checks++;
        if (a_status !== 8'h80) begin
            failures++; $display("FAIL single_idle got=%h exp=%h", a_status, 8'h80);
        end
    endtask

    task automatic test_col_enable();
        a_row = 2'd1; a_last = 1'b1; a_en = 4'b0101; a_data = 32'h44332211; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        checks++;
        if (a_w !== {4'b0101, 8'b0001_0001, 32'h00330011}) begin
            failures++; $display("FAIL col_enable got=%h exp=%h", a_w, {4'b0101, 8'b0001_0001, 32'h00330011});
        end
        repeat (5) tick();
        checks++;
        if (a_status !== 8'h80) begin
            failures++; $display("FAIL col_enable_idle got=%h exp=%h", a_status, 8'h80);
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] exp_s;
        a_en = 4'hF; a_row = 2'd3; a_last = 1'b0; a_data = 32'h0F0E0D0C; a_valid = 1'b1;
        tick();
        checks++;
        if (a_w !== {4'hF, 8'hFF, 32'h0F0E0D0C}) begin
            failures++; $display("FAIL bubble_first got=%h exp=%h", a_w, {4'hF, 8'hFF, 32'h0F0E0D0C});
        end
        a_valid = 1'b0;
        tick();
        checks++;
        if (a_w !== 44'h0 || a_status !== 8'hC0) begin
            failures++; $display("FAIL bubble_gap got=%h/%h exp=0/c0", a_w, a_status);
        end
        a_data = 32'h1F1E1D1C; a_last = 1'b1; a_valid = 1'b1;
        tick();
        checks++;
        if (a_w !== {4'hF, 8'hFF, 32'h1F1E1D1C}) begin
            failures++; $display("FAIL bubble_overwrite got=%h exp=%h", a_w, {4'hF, 8'hFF, 32'h1F1E1D1C});
        end
        // Keep offering a beat through DRAIN and SWITCH; it must not be taken.
        a_row = 2'd1; a_last = 1'b0; a_data = 32'h55555555;
        for (int r = 0; r < 4; r++) begin
            tick();
            exp_s = {1'b0, 1'b1, (r == 3), 1'b0, 4'(1 << r)};
            checks++;
            if (a_w !== 44'h0 || a_status !== exp_s) begin
                failures++; $display("FAIL bubble_switch step=%0d got=%h/%h exp=0/%h", r, a_w, a_status, exp_s);
            end
        end
        a_valid = 1'b0;
        tick();
        checks++;
        if (a_w !== 44'h0 || a_status !== 8'h80) begin
            failures++; $display("FAIL bubble_end got=%h/%h exp=0/80", a_w, a_status);
        end
    endtask

    task automatic test_reset_during_switch();
        logic [4:0] seen;
        a_row = 2'd0; a_last = 1'b1; a_en = 4'hF; a_data = 32'h01020304; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (a_status !== 8'h42) begin
            failures++; $display("FAIL abort_pre got=%h exp=%h", a_status, 8'h42);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a_status !== 8'h00 || a_w !== 44'h0) begin
            failures++; $display("FAIL abort_in_rst got=%h/%h exp=0/0", a_status, a_w);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (a_status !== 8'h80) begin
            failures++; $display("FAIL abort_release got=%h exp=%h", a_status, 8'h80);
        end
        seen = '0;
        repeat (6) begin
            tick();
            seen = seen | {a_done, a_sw};
        end
        checks++;
        if (seen !== 5'h0) begin
            failures++; $display("FAIL abort_no_pulse got=%h exp=%h", seen, 5'h0);
        end
    endtask

    task automatic test_row_oob();
        b_en = 6'h3F; b_row = 3'd5; b_last = 1'b0; b_data = 48'h605040302010; b_valid = 1'b1;
        tick();
        checks++;
        if (b_w !== {6'h3F, {6{3'd5}}, 48'h605040302010} || b_err !== 1'b0) begin
            failures++; $display("FAIL oob_row5 got=%h err=%b exp=%h err=0", b_w, b_err,
                                 {6'h3F, {6{3'd5}}, 48'h605040302010});
        end
        b_row = 3'd7; b_last = 1'b1;
        tick();
        b_valid = 1'b0;
        checks++;
        if (b_w !== 72'h0 || b_err !== 1'b1) begin
            failures++; $display("FAIL oob_row7 got=%h err=%b exp=0 err=1", b_w, b_err);
        end
        repeat (7) tick();
        checks++;
        if ({b_busy, b_err, b_ready} !== 3'b011) begin
            failures++; $display("FAIL oob_idle got=%b exp=%b", {b_busy, b_err, b_ready}, 3'b011);
        end
        b_row = 3'd2; b_last = 1'b1; b_data = 48'hFFEEDDCCBBAA; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        checks++;
        if (b_w !== {6'h3F, {6{3'd2}}, 48'hFFEEDDCCBBAA} || b_err !== 1'b1) begin
            failures++; $display("FAIL oob_next_load got=%h err=%b exp=%h err=1", b_w, b_err,
                                 {6'h3F, {6{3'd2}}, 48'hFFEEDDCCBBAA});
        end
        repeat (7) tick();
        checks++;
        if ({b_busy, b_err} !== 2'b01) begin
            failures++; $display("FAIL oob_sticky got=%b exp=%b", {b_busy, b_err}, 2'b01);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (b_err !== 1'b0) begin
            failures++; $display("FAIL oob_clear got=%b exp=0", b_err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_sequence();
        test_single_beat();
        test_col_enable();
        test_bubbles();
        test_reset_during_switch();
        test_row_oob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
